// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter and its deferred-write queue.
// Falls back to the classic 5-bit/32-bit buses when the shared defines are absent.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h00000000
`endif

package regfile_wport_arbiter_pkg;

  typedef logic [`RegAddrBus] reg_addr_t;
  typedef logic [`RegBus]     reg_data_t;

  localparam int unsigned ADDR_W = $bits(reg_addr_t);
  localparam int unsigned DATA_W = $bits(reg_data_t);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/regfile_wq.sv
// Deferred-write ring queue: storage, pointers, valid bits and address compares.
// Killed entries leave invalid holes that are reclaimed silently when they reach the head.
module regfile_wq
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wq_entry_t                    push_entry,
  input  logic                         pop,
  input  logic                         kill,
  input  reg_addr_t                    kill_addr,
  input  reg_addr_t                    cmp_addr1,
  input  reg_addr_t                    cmp_addr2,
  output logic                         head_valid,
  output wq_entry_t                    head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         hit1,
  output logic                         hit2
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wq_entry_t          mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W:0]     rptr;
  logic [PTR_W:0]     wptr;
  logic [PTR_W:0]     occ;
  logic [PTR_W-1:0]   ridx;
  logic [PTR_W-1:0]   widx;
  logic               reclaim;
  logic               advance;
  logic [DEPTH-1:0]   kill_vec;
  logic [DEPTH-1:0]   match1;
  logic [DEPTH-1:0]   match2;

  // Extra pointer bit separates a full ring from an empty one.
  assign ridx       = rptr[PTR_W-1:0];
  assign widx       = wptr[PTR_W-1:0];
  assign occ        = wptr - rptr;
  assign full       = (occ == (PTR_W+1)'(DEPTH));
  assign head_valid = (occ != '0) && valid[ridx];
  assign head_entry = mem[ridx];
  assign reclaim    = (occ != '0) && !valid[ridx];
  assign advance    = (pop && head_valid) || reclaim;

  always_comb begin
    kill_vec = '0;
    match1   = '0;
    match2   = '0;
    count    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_vec[i] = kill && valid[i] && (mem[i].addr == kill_addr);
      match1[i]   = valid[i] && (mem[i].addr == cmp_addr1);
      match2[i]   = valid[i] && (mem[i].addr == cmp_addr2);
      count       = count + CNT_W'(valid[i]);
    end
  end

  assign hit1 = |match1;
  assign hit2 = |match2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      valid <= '0;
    end else begin
      if (advance) rptr <= rptr + (PTR_W+1)'(1);
      if (push)    wptr <= wptr + (PTR_W+1)'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_vec[i] || (advance && (ridx == PTR_W'(i)))) valid[i] <= 1'b0;
        if (push && (widx == PTR_W'(i)))                     valid[i] <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) mem[widx] <= push_entry;
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single regfile write port between pipeline write-back and a
// multi-cycle unit; optional same-cycle bypass under RF_ARB_BYPASS_EN.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [`RegAddrBus] wb_waddr,
  input  logic [`RegBus]    wb_wdata,
  input  logic              mc_req,
  input  logic [`RegAddrBus] mc_waddr,
  input  logic [`RegBus]    mc_wdata,
  output logic              mc_ack,
  output logic              rf_we,
  output logic [`RegAddrBus] rf_waddr,
  output logic [`RegBus]    rf_wdata,
  input  logic              re1,
  input  logic [`RegAddrBus] raddr1,
  input  logic              re2,
  input  logic [`RegAddrBus] raddr2,
  output logic              stall_req
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

  logic             wb_fire;
  logic             mc_take;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             head_valid;
  logic             full;
  logic             hit1;
  logic             hit2;
  logic             hazard;
  logic             starve;
  wq_entry_t        push_entry;
  wq_entry_t        head_entry;
  logic [CNT_W-1:0] count;
  logic [AGE_W-1:0] age;

  // Capacity is judged before this cycle's pop, so a full queue never accepts.
  assign wb_fire    = rst && wb_we && (wb_waddr != '0);
  assign mc_ack     = rst && mc_req && (count < CNT_W'(DEPTH)) && !full;
  assign mc_take    = mc_ack && (mc_waddr != '0);
`ifdef RF_ARB_BYPASS_EN
  assign bypass     = mc_take && !wb_fire && (count == '0);
`else
  assign bypass     = 1'b0;
`endif
  assign push       = mc_take && !bypass;
  assign pop        = !wb_fire && head_valid;
  assign push_entry = '{addr: mc_waddr, data: mc_wdata};

  regfile_wq #(.DEPTH(DEPTH)) u_wq (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill       (wb_fire),
    .kill_addr  (wb_waddr),
    .cmp_addr1  (raddr1),
    .cmp_addr2  (raddr2),
    .head_valid (head_valid),
    .head_entry (head_entry),
    .count      (count),
    .full       (full),
    .hit1       (hit1),
    .hit2       (hit2)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = `ZeroWord;
    if (wb_fire) begin
      rf_we    = 1'b1;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (pop) begin
      rf_we    = 1'b1;
      rf_waddr = head_entry.addr;
      rf_wdata = head_entry.data;
    end else if (bypass) begin
      rf_we    = 1'b1;
      rf_waddr = mc_waddr;
      rf_wdata = mc_wdata;
    end
  end

  // Head age: how long the oldest live entry has been locked out by WB traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age <= '0;
    end else if (pop || !head_valid) begin
      age <= '0;
    end else if (age != AGE_W'(STARVE_LIMIT)) begin
      age <= age + AGE_W'(1);
    end
  end

  assign starve    = (age == AGE_W'(STARVE_LIMIT));
  assign hazard    = (re1 && (raddr1 != '0) && hit1) || (re2 && (raddr2 != '0) && hit2);
  assign stall_req = rst && (hazard || starve);

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: scoreboard of expected regfile
// writes plus per-scenario inline checks of ack, stall and write-port values.
module tb_regfile_wport_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
`ifdef RF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          mc_req;
  logic [AW-1:0] mc_waddr;
  logic [DW-1:0] mc_wdata;
  logic          mc_ack;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic          stall_req;

  wr_t           exp_q[$];
  logic [DW-1:0] regs [32];
  int            checks = 0;
  int            errors = 0;

  regfile_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .mc_req    (mc_req),
    .mc_waddr  (mc_waddr),
    .mc_wdata  (mc_wdata),
    .mc_ack    (mc_ack),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .re2       (re2),
    .raddr2    (raddr2),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  // Every regfile write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b1 && rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_unexpected: got write r%0d=0x%08h, required no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL rf_order: got r%0d=0x%08h, required r%0d=0x%08h", rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
      regs[rf_waddr] = rf_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    mc_req = 1'b0; mc_waddr = '0; mc_wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
  endtask

  task automatic exp_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h55;
    mc_req = 1'b1; mc_waddr = 5'd3; mc_wdata = 32'h33;
    re1 = 1'b1; raddr1 = 5'd3;
    #2;
    checks++;
    if (rf_we !== 1'b0 || mc_ack !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rf_we=%b mc_ack=%b stall=%b, required 0/0/0", rf_we, mc_ack, stall_req);
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || stall_req !== 1'b0 || mc_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rf_we=%b waddr=%0d wdata=0x%08h stall=%b ack=%b, required all 0",
               rf_we, rf_waddr, rf_wdata, stall_req, mc_ack);
    end
    tick();
  endtask

  task automatic test_wb_priority();
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h11;
    mc_req = 1'b1; mc_waddr = 5'd6; mc_wdata = 32'h22;
    exp_push(5'd5, 32'h11);
    exp_push(5'd6, 32'h22);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11 || mc_ack !== 1'b1) begin
      errors++;
      $display("FAIL wb_priority: got we=%b r%0d=0x%08h ack=%b, required 1 r5=0x00000011 ack=1",
               rf_we, rf_waddr, rf_wdata, mc_ack);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h22) begin
      errors++;
      $display("FAIL deferred_write: got we=%b r%0d=0x%08h, required 1 r6=0x00000022", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      errors++;
      $display("FAIL idle_port: got we=%b waddr=%0d wdata=0x%08h, required 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_mc_latency();
    idle_inputs();
    mc_req = 1'b1; mc_waddr = 5'd3; mc_wdata = 32'h33;
    exp_push(5'd3, 32'h33);
    @(negedge clk);
    checks++;
    if (mc_ack !== 1'b1 || rf_we !== BYP) begin
      errors++;
      $display("FAIL mc_latency: got ack=%b rf_we=%b, required ack=1 rf_we=%b", mc_ack, rf_we, BYP);
    end
    tick();
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_full();
    logic exp_ack [6];
    exp_ack[0] = 1'b1; exp_ack[1] = 1'b1; exp_ack[2] = 1'b0;
    exp_ack[3] = 1'b0; exp_ack[4] = 1'b0; exp_ack[5] = 1'b1;
    for (int c = 0; c < 4; c++) exp_push(5'(20 + c), 32'hB00 + 32'(c));
    exp_push(5'd10, 32'hA0);
    exp_push(5'd11, 32'hA1);
    exp_push(5'd12, 32'hA2);
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      wb_we = (c < 4);
      wb_waddr = 5'(20 + c);
      wb_wdata = 32'hB00 + 32'(c);
      mc_req = 1'b1;
      mc_waddr = (c < 2) ? 5'(10 + c) : 5'd12;
      mc_wdata = (c < 2) ? 32'hA0 + 32'(c) : 32'hA2;
      @(negedge clk);
      checks++;
      if (mc_ack !== exp_ack[c]) begin
        errors++;
        $display("FAIL full_ack[%0d]: got mc_ack=%b, required %b", c, mc_ack, exp_ack[c]);
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_waw_kill();
    wb_we = 1'b1; wb_waddr = 5'd8; wb_wdata = 32'h88;
    mc_req = 1'b1; mc_waddr = 5'd7; mc_wdata = 32'h77;
    exp_push(5'd8, 32'h88);
    tick();
    idle_inputs();
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hAA;
    exp_push(5'd7, 32'hAA);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hAA) begin
      errors++;
      $display("FAIL waw_wb: got we=%b r%0d=0x%08h, required 1 r7=0x000000aa", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin
        errors++;
        $display("FAIL waw_stale[%0d]: got rf_we=%b r%0d=0x%08h, required no write", c, rf_we, rf_waddr, rf_wdata);
      end
      tick();
    end
    checks++;
    if (regs[7] !== 32'hAA) begin
      errors++;
      $display("FAIL waw_r7: got 0x%08h, required 0x000000aa", regs[7]);
    end
    // Freed capacity: two requests under WB traffic must both be accepted.
    for (int c = 0; c < 2; c++) exp_push(5'(16 + c), 32'hD0 + 32'(c));
    exp_push(5'd14, 32'hE4);
    exp_push(5'd15, 32'hE5);
    for (int c = 0; c < 2; c++) begin
      wb_we = 1'b1; wb_waddr = 5'(16 + c); wb_wdata = 32'hD0 + 32'(c);
      mc_req = 1'b1; mc_waddr = 5'(14 + c); mc_wdata = 32'hE4 + 32'(c);
      @(negedge clk);
      checks++;
      if (mc_ack !== 1'b1) begin
        errors++;
        $display("FAIL waw_capacity[%0d]: got mc_ack=%b, required 1", c, mc_ack);
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_hazard();
    logic [AW-1:0] wb_a [5];
    logic          r1_en [6];
    logic [AW-1:0] r1_a [6];
    logic          r2_en [6];
    logic          exp_stall [6];
    wb_a[0] = 5'd1; wb_a[1] = 5'd2; wb_a[2] = 5'd3; wb_a[3] = 5'd17; wb_a[4] = 5'd18;
    r1_en[0] = 1'b0; r1_en[1] = 1'b1; r1_en[2] = 1'b1; r1_en[3] = 1'b0; r1_en[4] = 1'b0; r1_en[5] = 1'b1;
    r1_a[0] = 5'd0;  r1_a[1] = 5'd9;  r1_a[2] = 5'd0;  r1_a[3] = 5'd9;  r1_a[4] = 5'd0;  r1_a[5] = 5'd9;
    r2_en[0] = 1'b0; r2_en[1] = 1'b0; r2_en[2] = 1'b0; r2_en[3] = 1'b0; r2_en[4] = 1'b1; r2_en[5] = 1'b0;
    exp_stall[1] = 1'b1; exp_stall[2] = 1'b0; exp_stall[3] = 1'b0; exp_stall[4] = 1'b1;
    exp_stall[0] = 1'b0; exp_stall[5] = 1'b0;
    for (int c = 0; c < 5; c++) exp_push(wb_a[c], 32'h100 + 32'(c));
    exp_push(5'd9, 32'h99);
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c < 5) begin
        wb_we = 1'b1; wb_waddr = wb_a[c]; wb_wdata = 32'h100 + 32'(c);
      end
      if (c == 0) begin
        mc_req = 1'b1; mc_waddr = 5'd9; mc_wdata = 32'h99;
      end
      re1 = r1_en[c]; raddr1 = r1_a[c];
      re2 = r2_en[c]; raddr2 = 5'd9;
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        checks++;
        if (stall_req !== exp_stall[c]) begin
          errors++;
          $display("FAIL hazard[%0d]: got stall_req=%b, required %b", c, stall_req, exp_stall[c]);
        end
      end
      tick();
    end
    idle_inputs();
    re1 = 1'b1; raddr1 = 5'd9;
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL hazard_after_pop: got stall_req=%b, required 0", stall_req);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_starvation();
    wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'hF1;
    mc_req = 1'b1; mc_waddr = 5'd4; mc_wdata = 32'h44;
    exp_push(5'd1, 32'hF1);
    for (int j = 1; j <= 9; j++) exp_push(5'(16 + j), 32'hC00 + 32'(j));
    exp_push(5'd4, 32'h44);
    tick();
    idle_inputs();
    for (int j = 1; j <= 9; j++) begin
      wb_we = 1'b1; wb_waddr = 5'(16 + j); wb_wdata = 32'hC00 + 32'(j);
      @(negedge clk);
      checks++;
      if (stall_req !== (j == 9)) begin
        errors++;
        $display("FAIL starve[%0d]: got stall_req=%b, required %b", j, stall_req, (j == 9));
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4) begin
      errors++;
      $display("FAIL starve_pop: got we=%b r%0d, required 1 r4", rf_we, rf_waddr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL starve_clear: got stall_req=%b, required 0", stall_req);
    end
    tick();
  endtask

  task automatic test_zero_addr();
    idle_inputs();
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hDEAD;
    mc_req = 1'b1; mc_waddr = 5'd0; mc_wdata = 32'hBEEF;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || mc_ack !== 1'b1) begin
      errors++;
      $display("FAIL zero_addr: got rf_we=%b mc_ack=%b, required 0/1", rf_we, mc_ack);
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin
        errors++;
        $display("FAIL zero_dropped[%0d]: got rf_we=%b r%0d, required 0", c, rf_we, rf_waddr);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      a = 5'($urandom_range(31, 1));
      d = $urandom;
      mc_req = 1'b1; mc_waddr = a; mc_wdata = d;
      exp_push(a, d);
      @(negedge clk);
      checks++;
      if (mc_ack !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ack[%0d]: got mc_ack=%b, required 1", c, mc_ack);
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      wb_we = 1'b1; wb_waddr = 5'(1 + c); wb_wdata = 32'h200 + 32'(c);
      mc_req = 1'b1; mc_waddr = 5'(12 + c); mc_wdata = 32'hC1 + 32'(c);
      exp_push(5'(1 + c), 32'h200 + 32'(c));
      tick();
    end
    idle_inputs();
    re1 = 1'b1; raddr1 = 5'd12;
    rst = 1'b0;
    #2;
    checks++;
    if (rf_we !== 1'b0 || stall_req !== 1'b0 || mc_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got rf_we=%b stall=%b ack=%b, required 0/0/0", rf_we, stall_req, mc_ack);
    end
    repeat (2) tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || stall_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale[%0d]: got rf_we=%b r%0d stall=%b, required 0/0", c, rf_we, rf_waddr, stall_req);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_wb_priority();
    test_mc_latency();
    test_full();
    test_waw_kill();
    test_hazard();
    test_starvation();
    test_zero_addr();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding writes, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
